alu_cmd_seq: RTL

ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_cmd_seq_if.sv | 40 ++++
 rtl/alu_cmd_fifo.sv | 74 +++++++
 rtl/alu_cmd_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU command sequencer: opcode
//                constants, sequencer state encoding and the queued command
//                record {sel, a, b}.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SHL  = 4'b0100;
    localparam logic [3:0] OP_SHR  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_seq_if
//  Description : Bus bundle of the ALU command sequencer.
//                Command side : cmd_valid/cmd_ready, cmd_sel, cmd_a, cmd_b
//                ALU side     : alu_sel, alu_a, alu_b (drive), alu_out (result)
//                Result side  : res_valid/res_ready, res_data, res_err
//                Status       : busy
//                slave  = the sequencer, master = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_seq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_sel;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [3:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_err;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_out, res_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_err, busy
    );

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_out, res_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : DEPTH-entry in-order command FIFO (DEPTH = 2, 4 or 8).
//                Ports: clk, rst, push/din, pop/dout (head, combinational),
//                full, empty, count (clog2(DEPTH)+1 bits).
//                Push is ignored when full, pop is ignored when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     din,
    input  logic                     pop,
    output cmd_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    cmd_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_seq
//  Description : Queues ALU commands, drives them one at a time onto a
//                registered ALU interface, captures the combinational result
//                one cycle later and offers it on a valid/ready result port.
//                Ports: clk, rst (sync, active-high), bus (alu_cmd_seq_if.slave).
//                Parameter DEPTH: command FIFO depth (2, 4 or 8).
//                Build option ALU_CMD_SEQ_DIVZ_EN: flag divide-by-zero
//                (res_err=1, res_data=4'b1111); otherwise res_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_cmd_seq_if.slave  bus
);

    cmd_t                  w_din;
    cmd_t                  w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                  w_pop;
    logic [3:0]            w_res_data;
    logic                  w_res_err;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [3:0] r_alu_sel;
    logic [3:0] r_res_data;
    logic       r_res_err;

    assign w_din = {bus.cmd_sel, bus.cmd_a, bus.cmd_b};

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Next state and pop. A result handshake pops the next head on the same
    // edge so a busy stream sustains one result every two cycles.
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = EXEC;
                end
            end
            EXEC: begin
                w_next = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    if (!w_empty) begin
                        w_pop  = 1'b1;
                        w_next = EXEC;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ALU drive changes only when a command is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a   <= 4'd0;
            r_alu_b   <= 4'd0;
            r_alu_sel <= 4'd0;
        end else if (w_pop) begin
            r_alu_a   <= w_head.a;
            r_alu_b   <= w_head.b;
            r_alu_sel <= w_head.sel;
        end
    end

`ifdef ALU_CMD_SEQ_DIVZ_EN
    logic w_divz;
    assign w_divz     = (r_alu_sel == OP_DIV) && (r_alu_b == 4'd0);
    assign w_res_err  = w_divz;
    assign w_res_data = w_divz ? 4'b1111 : bus.alu_out;
`else
    assign w_res_err  = 1'b0;
    assign w_res_data = bus.alu_out;
`endif

    // The ALU has had the whole EXEC cycle to settle; capture at its end.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_data <= 4'd0;
            r_res_err  <= 1'b0;
        end else if (r_state == EXEC) begin
            r_res_data <= w_res_data;
            r_res_err  <= w_res_err;
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_sel   = r_alu_sel;
    assign bus.res_valid = (r_state == RESP);
    assign bus.res_data  = r_res_data;
    assign bus.res_err   = r_res_err;
    assign bus.busy      = (w_count != '0) || (r_state != IDLE);

endmodule
`default_nettype wire
